// File: rtl/masked_sbox_driver.sv
// Initiator-side sequencer for one clock-gated masked 4-bit S-box core.
// Optional build macro MASKED_SBOX_DRV_PRNG_EN: sbox_fresh comes from an internal LFSR instead of rnd_in.
module masked_sbox_driver #(
  parameter int SECURITY_ORDER = 3,
  parameter int FRESH_WIDTH = 130,
  parameter int LATENCY = 10,
  parameter int SLACK = 2,
  parameter logic [FRESH_WIDTH-1:0] PRNG_SEED = 130'h1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [4*(SECURITY_ORDER+1)-1:0] in_s,
  input  logic [FRESH_WIDTH-1:0] rnd_in,
  output logic out_valid,
  input  logic out_ready,
  output logic [4*(SECURITY_ORDER+1)-1:0] out_s,
  output logic [4*(SECURITY_ORDER+1)-1:0] sbox_si,
  output logic [FRESH_WIDTH-1:0] sbox_fresh,
  output logic sbox_rst,
  input  logic [4*(SECURITY_ORDER+1)-1:0] sbox_so,
  input  logic sbox_synch,
  output logic err,
  input  logic err_clr
);

  // state | meaning
  // IDLE  | core held in reset, waiting for an input nibble
  // LOAD  | shares/randomness latched, one more reset cycle for the core
  // RUN   | core released, counting cycles until Synch
  // DONE  | output shares held until the consumer takes them
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam int CW = $clog2(LATENCY + SLACK + 2);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);
  localparam logic [CW-1:0] MAX_C = CW'(LATENCY + SLACK + 1);

  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic accept, capture, err_set;
  logic [FRESH_WIDTH-1:0] fresh_src;

`ifdef MASKED_SBOX_DRV_PRNG_EN
  logic [FRESH_WIDTH-1:0] lfsr;
  logic unused_rnd;
  assign unused_rnd = ^rnd_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= PRNG_SEED;
    else      lfsr <= {lfsr[FRESH_WIDTH-2:0], lfsr[FRESH_WIDTH-1] ^ lfsr[FRESH_WIDTH-2]
                                           ^ lfsr[FRESH_WIDTH-5] ^ lfsr[FRESH_WIDTH-6]};
  end
  assign fresh_src = lfsr;
`else
  assign fresh_src = rnd_in;
`endif

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        accept   = 1'b1;
        state_nx = LOAD;
      end
      LOAD: state_nx = RUN;
      RUN: begin
        // Timeout wins over a late Synch: anything past the window is an error.
        if (cnt >= MAX_C) begin
          err_set  = 1'b1;
          state_nx = IDLE;
        end else if (sbox_synch) begin
          if (cnt < LAT_C) begin
            err_set  = 1'b1;
            state_nx = IDLE;
          end else begin
            capture  = 1'b1;
            state_nx = DONE;
          end
        end
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // All core-facing signals are plain flop outputs so no glitch reaches the masked logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_s      <= '0;
      sbox_si    <= '0;
      sbox_fresh <= '0;
      sbox_rst   <= 1'b1;
      err        <= 1'b0;
    end else begin
      sbox_rst <= (state_nx != RUN);
      if (state == LOAD)
        cnt <= '0;
      else if (state == RUN && cnt != MAX_C)
        cnt <= cnt + 1'b1;
      if (accept) begin
        sbox_si    <= in_s;
        sbox_fresh <= fresh_src;
      end
      if (capture) begin
        out_s     <= sbox_so;
        out_valid <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid <= 1'b0;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_sbox_driver.sv
// Randomized self-checking bench for masked_sbox_driver with a behavioural core model.
module tb_masked_sbox_driver;
  localparam int SW = 16;
  localparam int FW = 130;
  localparam int LAT = 10;
  localparam int SLK = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [SW-1:0] in_s = '0;
  logic [FW-1:0] rnd_in = '0;
  logic out_valid, out_ready = 1'b0;
  logic [SW-1:0] out_s, sbox_si, sbox_so = '0;
  logic [FW-1:0] sbox_fresh;
  logic sbox_rst, sbox_synch = 1'b0, err, err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  bit exp_err = 1'b0;
  int unsigned cyc;

  logic [3:0] sbox_tab [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                                4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};

  masked_sbox_driver dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_s(in_s),
    .rnd_in(rnd_in), .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s),
    .sbox_si(sbox_si), .sbox_fresh(sbox_fresh), .sbox_rst(sbox_rst), .sbox_so(sbox_so),
    .sbox_synch(sbox_synch), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] share_xor(input logic [SW-1:0] s);
    return s[3:0] ^ s[7:4] ^ s[11:8] ^ s[15:12];
  endfunction

  function automatic logic [SW-1:0] rand_shares(input logic [3:0] v);
    logic [SW-1:0] s;
    s = SW'($urandom);
    s[15:12] = v ^ s[3:0] ^ s[7:4] ^ s[11:8];
    return s;
  endfunction

  function automatic logic [FW-1:0] rand_wide();
    logic [159:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return w[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] lfsr_after(input int unsigned n);
    logic [FW-1:0] v;
    v = 130'h1;
    for (int unsigned i = 0; i < n; i++)
      v = {v[FW-2:0], v[FW-1] ^ v[FW-2] ^ v[FW-5] ^ v[FW-6]};
    return v;
  endfunction

  // One full transaction; synch_at is the RUN counter value at which the core model raises Synch.
  task automatic txn(input logic [SW-1:0] sh, input int synch_at, input int hold, input bit clr_at_synch);
    logic [FW-1:0] rnd, efresh;
    logic [SW-1:0] so;
    logic [3:0] val;
    int k;
    bit done;
    val = share_xor(sh);
    rnd = rand_wide();
    so = '0;
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    in_s = sh;
    rnd_in = rnd;
`ifdef MASKED_SBOX_DRV_PRNG_EN
    efresh = lfsr_after(cyc);
`else
    efresh = rnd;
`endif
    @(negedge clk);
    in_valid = 1'b0;
    in_s = SW'($urandom);
    rnd_in = rand_wide();
    chk("load_si", sbox_si, sh);
    chk("load_fresh", sbox_fresh, efresh);
    chk("load_sbox_rst", sbox_rst, 1);
    chk("load_ready", in_ready, 0);
    @(negedge clk);
    k = 0;
    done = 1'b0;
    while (!done) begin
      chk("run_sbox_rst", sbox_rst, 0);
      chk("run_si", sbox_si, sh);
      chk("run_fresh", sbox_fresh, efresh);
      chk("run_out_valid", out_valid, 0);
      rnd_in = rand_wide();
      if (k == synch_at) begin
        so = rand_shares(sbox_tab[val]);
        sbox_so = so;
        sbox_synch = 1'b1;
        err_clr = clr_at_synch;
      end
      @(negedge clk);
      sbox_synch = 1'b0;
      err_clr = 1'b0;
      sbox_so = SW'($urandom);
      if (k == synch_at || k == LAT + SLK + 1) done = 1'b1;
      k++;
    end
    if (synch_at >= LAT && synch_at <= LAT + SLK) begin
      if (clr_at_synch) exp_err = 1'b0;
      for (int i = 0; i <= hold; i++) begin
        if (i == hold) out_ready = 1'b1;
        chk("done_out_valid", out_valid, 1);
        chk("done_out_s", out_s, so);
        chk("done_xor", share_xor(out_s), sbox_tab[val]);
        chk("done_ready", in_ready, 0);
        chk("done_sbox_rst", sbox_rst, 1);
        @(negedge clk);
      end
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 0);
    end else begin
      exp_err = 1'b1;
      chk("abort_out_valid", out_valid, 0);
    end
    chk("end_ready", in_ready, 1);
    chk("end_err", err, exp_err);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_sbox_rst"}, sbox_rst, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_out_s"}, out_s, 0);
    chk({tag, "_si"}, sbox_si, 0);
    chk({tag, "_fresh"}, sbox_fresh, 0);
  endtask

  initial begin
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    txn(16'hF953, LAT, 0, 1'b0);
    txn(rand_shares(4'h5), LAT, 7, 1'b0);
    txn(rand_shares(4'h3), LAT + SLK, 2, 1'b0);
    txn(rand_shares(4'h9), 6, 0, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk("err_clr", err, 0);
    txn(rand_shares(4'hA), -1, 0, 1'b0);
    txn(rand_shares(4'h1), LAT - 1, 0, 1'b1);
    txn(rand_shares(4'h7), LAT + SLK + 1, 0, 1'b0);
    txn(rand_shares(4'hE), LAT + 1, 1, 1'b1);

    // Reset while the core is running.
    in_valid = 1'b1;
    in_s = rand_shares(4'h2);
    rnd_in = rand_wide();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_run_sbox_rst", sbox_rst, 0);
    rst = 1'b0;
    #1;
    exp_err = 1'b0;
    reset_checks("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(rand_shares(4'h2), LAT, 0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      int sa;
      sa = int'($urandom_range(4, 15));
      txn(rand_shares(4'($urandom)), sa, int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = 1'b0;
        chk("rand_err_clr", err, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
